// File: rtl/calculate_velocity.sv
// Velocity integrator for the teeter ball model: on every prescaled physics tick it
// bounces, accelerates, damps and saturates the velocity, then publishes it with a strobe.
module calculate_velocity #(
    parameter int TICK_DIV       = 1000000,
    parameter int ACCEL_SHIFT    = 0,
    parameter int FRICTION_SHIFT = 5,
    parameter int BOUNCE_SHIFT   = 1,
    parameter int VMAX           = 256
) (
    input  logic        CLK,
    input  logic        i_rst,
    input  logic        i_enable,
    input  logic [7:0]  i_tilt,
    input  logic        i_hit_low,
    input  logic        i_hit_high,
    output logic [31:0] o_velocity,
    output logic        o_calc_time
);

    localparam int CNT_W = $clog2(TICK_DIV);

    typedef enum logic [1:0] {IDLE, ACCEL, DAMP, ISSUE} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               tick;
    logic signed [31:0] v;
    logic signed [31:0] accel;
    logic signed [31:0] v_accel;
    logic signed [31:0] mag;
    logic signed [31:0] friction;
    logic signed [31:0] v_fric;
    logic signed [31:0] v_damp;

    assign tick  = i_enable && (cnt == CNT_W'(TICK_DIV - 1));
    assign accel = $signed({{24{i_tilt[7]}}, i_tilt}) <<< ACCEL_SHIFT;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        v_accel = v;
        if (i_hit_low && i_hit_high) begin
            v_accel = '0;
        end else begin
            if (i_hit_low && v < 0)
                v_accel = (-v) >>> BOUNCE_SHIFT;
            else if (i_hit_high && v > 0)
                v_accel = -(v >>> BOUNCE_SHIFT);
            v_accel = v_accel + accel;
        end
    end

    // Friction works on the magnitude so it pulls symmetrically toward zero.
    always_comb begin
        mag      = v[31] ? -v : v;
        friction = mag >>> FRICTION_SHIFT;
        v_fric   = v[31] ? v + friction : v - friction;
        v_damp   = v_fric;
        if (v_fric > VMAX)
            v_damp = VMAX;
        else if (v_fric < -VMAX)
            v_damp = -VMAX;
    end

    // NOTE: state registers use non-blocking assignments; reset is synchronous and wins over all.
    always_ff @(posedge CLK) begin
        if (i_rst)
            cnt <= '0;
        else if (tick)
            cnt <= '0;
        else if (i_enable)
            cnt <= cnt + CNT_W'(1);
    end

    // The damped value is loaded into o_velocity on the same edge that raises the strobe,
    // so the downstream stage sees a fresh velocity exactly while o_calc_time is high.
    always_ff @(posedge CLK) begin
        if (i_rst) begin
            state       <= IDLE;
            v           <= '0;
            o_velocity  <= '0;
            o_calc_time <= 1'b0;
        end else begin
            o_calc_time <= 1'b0;
            case (state)
                IDLE: begin
                    if (tick)
                        state <= ACCEL;
                end
                ACCEL: begin
                    v     <= v_accel;
                    state <= DAMP;
                end
                DAMP: begin
                    v           <= v_damp;
                    o_velocity  <= v_damp;
                    o_calc_time <= 1'b1;
                    state       <= ISSUE;
                end
                ISSUE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_calculate_velocity.sv
// Self-checking bench for calculate_velocity: directed physics cases with literal results,
// then randomized traffic compared every cycle against a tick-scheduled arithmetic model.
module tb_calculate_velocity;

    localparam int TD   = 4;
    localparam int AS   = 0;
    localparam int FS   = 5;
    localparam int BS   = 1;
    localparam int VMAX = 256;

    logic        CLK = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_enable = 1'b0;
    logic [7:0]  i_tilt = '0;
    logic        i_hit_low = 1'b0;
    logic        i_hit_high = 1'b0;
    logic [31:0] o_velocity;
    logic        o_calc_time;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_on   = 1'b0;

    calculate_velocity #(
        .TICK_DIV(TD), .ACCEL_SHIFT(AS), .FRICTION_SHIFT(FS),
        .BOUNCE_SHIFT(BS), .VMAX(VMAX)
    ) dut (
        .CLK(CLK), .i_rst(i_rst), .i_enable(i_enable), .i_tilt(i_tilt),
        .i_hit_low(i_hit_low), .i_hit_high(i_hit_high),
        .o_velocity(o_velocity), .o_calc_time(o_calc_time)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic signed [63:0] got,
                         input logic signed [63:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    endtask

    // Physics rules in plain integer arithmetic.
    function automatic int accel_step(int v, logic signed [7:0] tilt, logic hl, logic hh);
        int r;
        if (hl && hh) return 0;
        r = v;
        if (hl && v < 0)      r = (-v) / (1 << BS);
        else if (hh && v > 0) r = -(v / (1 << BS));
        return r + int'(tilt) * (1 << AS);
    endfunction

    function automatic int damp_step(int v);
        int m, r;
        m = (v < 0) ? -v : v;
        r = (v < 0) ? v + m / (1 << FS) : v - m / (1 << FS);
        if (r > VMAX)  r = VMAX;
        if (r < -VMAX) r = -VMAX;
        return r;
    endfunction

    // Model: remembers the cycle of the last tick and applies physics at tick+1 / tick+2.
    int cyc     = 0;
    int tick_at = -100;
    int m_cnt   = 0;
    int m_v     = 0;
    int m_out   = 0;
    bit m_strobe = 1'b0;

    always @(posedge CLK) begin
        cyc <= cyc + 1;
        if (i_rst) begin
            m_cnt    <= 0;
            m_v      <= 0;
            m_out    <= 0;
            m_strobe <= 1'b0;
            tick_at  <= -100;
        end else begin
            m_strobe <= 1'b0;
            if (cyc == tick_at + 1)
                m_v <= accel_step(m_v, $signed(i_tilt), i_hit_low, i_hit_high);
            if (cyc == tick_at + 2) begin
                m_v      <= damp_step(m_v);
                m_out    <= damp_step(m_v);
                m_strobe <= 1'b1;
            end
            if (i_enable && m_cnt == TD - 1)
                tick_at <= cyc;
            if (i_enable)
                m_cnt <= (m_cnt == TD - 1) ? 0 : m_cnt + 1;
        end
    end

    always @(negedge CLK) begin
        if (chk_on) begin
            check("strobe", o_calc_time, m_strobe);
            check("velocity", $signed(o_velocity), m_out);
        end
    end

    // Called at the start of a cycle; returns how many cycles later the strobe appeared.
    task automatic wait_strobe(output int n, output logic signed [31:0] vel);
        bit seen;
        n = -1;
        vel = '0;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge CLK);
            if (o_calc_time === 1'b1) begin
                n = k;
                vel = $signed(o_velocity);
                seen = 1'b1;
            end
            @(posedge CLK);
            #1;
        end
        if (!seen)
            check("strobe_timeout", 0, 1);
    endtask

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    // Leaves the bench at the start of release cycle 0 with enable high.
    task automatic do_reset(input logic [7:0] tilt);
        i_rst = 1'b1;
        i_enable = 1'b1;
        i_hit_low = 1'b0;
        i_hit_high = 1'b0;
        i_tilt = tilt;
        next_cycle();
        @(negedge CLK);
        check("reset_velocity", $signed(o_velocity), 0);
        check("reset_strobe", o_calc_time, 0);
        next_cycle();
        i_rst = 1'b0;
    endtask

    // Called right after a strobe (the next tick cycle); hits/tilt are junk outside ACCEL.
    task automatic accel_pulse(input logic [7:0] tilt, input logic hl, input logic hh,
                               output logic signed [31:0] vel);
        int n;
        i_tilt = 8'($urandom);
        i_hit_low = 1'($urandom);
        i_hit_high = 1'($urandom);
        next_cycle();
        i_tilt = tilt;
        i_hit_low = hl;
        i_hit_high = hh;
        next_cycle();
        i_tilt = 8'($urandom);
        i_hit_low = 1'($urandom);
        i_hit_high = 1'($urandom);
        wait_strobe(n, vel);
        check("pulse_latency", n, 1);
    endtask

    initial begin
        int n;
        int strobes;
        logic signed [31:0] vel;

        next_cycle();
        next_cycle();
        chk_on = 1'b1;

        // Constant tilt +16: first strobe at cycle TD+2 after release, then every TD.
        do_reset(8'd16);
        wait_strobe(n, vel);
        check("first_strobe_cycle", n, TD + 2);
        check("tilt16_v1", vel, 16);
        wait_strobe(n, vel);
        check("strobe_period", n, TD - 1);
        wait_strobe(n, vel);
        check("strobe_period2", n, TD - 1);

        // Full tilt runs into saturation.
        do_reset(8'd127);
        wait_strobe(n, vel);
        check("tilt127_v1", vel, 124);
        wait_strobe(n, vel);
        check("tilt127_v2", vel, 244);
        wait_strobe(n, vel);
        check("tilt127_v3", vel, 256);
        wait_strobe(n, vel);
        check("tilt127_hold", vel, 256);

        // Bounce off the low wall, then the high wall.
        do_reset(8'hC0);
        wait_strobe(n, vel);
        check("tilt_m64", vel, -62);
        accel_pulse(8'd0, 1'b1, 1'b0, vel);
        check("bounce_low", vel, 31);
        accel_pulse(8'd0, 1'b0, 1'b1, vel);
        check("bounce_high", vel, -15);

        // Low hit while moving away: friction only; both hits: dead stop.
        do_reset(8'd103);
        wait_strobe(n, vel);
        check("v_100", vel, 100);
        accel_pulse(8'd0, 1'b1, 1'b0, vel);
        check("hit_low_no_bounce", vel, 97);
        accel_pulse(8'd77, 1'b1, 1'b1, vel);
        check("both_hits", vel, 0);

        // Reset during DAMP aborts the sequence.
        i_tilt = 8'd40;
        wait_strobe(n, vel);
        next_cycle();
        next_cycle();
        i_rst = 1'b1;
        next_cycle();
        i_rst = 1'b0;
        @(negedge CLK);
        check("abort_no_strobe", o_calc_time, 0);
        check("abort_velocity", $signed(o_velocity), 0);
        next_cycle();
        wait_strobe(n, vel);
        check("strobe_after_abort", n, TD + 1);

        // Enable dropped right after a tick: in-flight strobe completes, then silence.
        wait_strobe(n, vel);
        next_cycle();
        i_enable = 1'b0;
        wait_strobe(n, vel);
        check("inflight_strobe", n, 2);
        strobes = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge CLK);
            if (o_calc_time === 1'b1) strobes++;
            next_cycle();
        end
        check("disabled_strobes", strobes, 0);
        i_enable = 1'b1;
        wait_strobe(n, vel);
        check("resume_strobe", n, TD + 2);

        // Randomized traffic with biased tilt phases to reach both saturation rails.
        do_reset(8'($urandom));
        for (int k = 0; k < 3000; k++) begin
            i_rst = ($urandom_range(0, 199) == 0);
            i_enable = ($urandom_range(0, 9) != 0);
            if (k < 600)
                i_tilt = 8'($urandom_range(64, 127));
            else if (k < 1200)
                i_tilt = 8'(-$urandom_range(64, 128));
            else
                i_tilt = 8'($urandom);
            i_hit_low = ($urandom_range(0, 3) == 0);
            i_hit_high = ($urandom_range(0, 3) == 0);
            next_cycle();
        end

        chk_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
